// File: rtl/arb_pkg.sv
// Shared constants and state type for the
// four-way round-robin grant arbiter.
package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int TEN_W   = 8;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search: first set req bit
// starting at (last+1) mod 4, wrapping upward.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] win,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0] cand;
   logic             found;

   // k = NUM_REQ wraps back onto last itself
   always_comb begin
      win   = '0;
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = last + IDX_W'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      win[idx] = found;
      any      = found;
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with bounded
// grant tenure and a timeout pulse on revoke.
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               timeout
);

   localparam logic [TEN_W-1:0] LIMIT =
      TEN_W'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0] LAST_RST =
      IDX_W'(NUM_REQ - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [TEN_W-1:0]   ten_q, ten_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [IDX_W-1:0]   idx_d;
   logic               vld_d;
   logic               to_d;

   logic [NUM_REQ-1:0] pick_win;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   logic               rel_norm;
   logic               at_limit;

   rr_pick4 u_pick (
      .req  (req),
      .last (last_q),
      .win  (pick_win),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // holder's own release wins over the limit
   assign rel_norm = done | ~req[gnt_idx];
   assign at_limit = (ten_q == LIMIT);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      ten_d   = ten_q;
      gnt_d   = gnt;
      idx_d   = gnt_idx;
      vld_d   = gnt_valid;
      to_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = BUSY;
               gnt_d   = pick_win;
               idx_d   = pick_idx;
               vld_d   = 1'b1;
               last_d  = pick_idx;
               ten_d   = '0;
            end
         end
         BUSY: begin
            if (rel_norm || at_limit) begin
               state_d = IDLE;
               gnt_d   = '0;
               idx_d   = '0;
               vld_d   = 1'b0;
               to_d    = ~rel_norm;
            end else if (ten_q != '1) begin
               ten_d = ten_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= LAST_RST;
         ten_q     <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         ten_q     <= ten_d;
         gnt       <= gnt_d;
         gnt_idx   <= idx_d;
         gnt_valid <= vld_d;
         timeout   <= to_d;
      end
   end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum grant tenure in cycles (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request level; bit i is requester i.
REQ-005 The block SHALL have port done, input, 1 bit: release strobe from the current grant holder; it is meaningful only while gnt_valid=1.
REQ-006 The block SHALL have port gnt, output, 4 bits: registered one-hot grant, or all-zero when idle.
REQ-007 The block SHALL have port gnt_idx, output, 2 bits: binary index of the set gnt bit; 2'b00 when idle.
REQ-008 The block SHALL have port gnt_valid, output, 1 bit: 1 exactly when gnt is nonzero.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-010 The FSM SHALL have two states: IDLE (gnt=0) and BUSY (exactly one gnt bit set).
REQ-011 IDLE with req!=0 at an edge SHALL go to BUSY at that edge, with gnt, gnt_idx and gnt_valid registered (1-cycle latency); IDLE with req=0 SHALL stay in IDLE.
REQ-012 The winner SHALL be the first set req bit searched from (last+1) mod 4 upward with wrap-around, where last is the index of the previous winner.
REQ-013 last SHALL update to the winner index on each IDLE->BUSY transition only.
REQ-014 In BUSY, gnt, gnt_idx and gnt_valid SHALL hold stable until release; changes on other req bits SHALL be ignored.
REQ-015 Release SHALL occur on any of: done=1; req[gnt_idx]=0; or the tenure counter reaching MAX_HOLD-1 without either of those.
REQ-016 On release the FSM SHALL return to IDLE with gnt=0 on the next cycle, giving one mandatory idle cycle between grants; re-arbitration occurs from that IDLE cycle.
REQ-017 The tenure counter SHALL clear to 0 on entering BUSY and increment by 1 per BUSY cycle; width SHALL be 8 bits, saturating and never wrapping.
REQ-018 timeout SHALL pulse high for exactly the cycle in which gnt drops due to the tenure limit.
REQ-019 done or req[gnt_idx]=0 coinciding with the tenure limit SHALL count as a normal release, with no timeout pulse.
REQ-020 done asserted in IDLE SHALL be ignored.
REQ-021 gnt SHALL never have more than one bit set, and SHALL never assert for a requester whose req was 0 at the granting edge.

Reset
REQ-022 rst_n=0 at an edge SHALL force: state IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, tenure counter=0, last=3 (so requester 0 has first priority).
REQ-023 Reset asserted mid-grant SHALL drop the grant at that edge with no timeout pulse.
REQ-024 Arbitration SHALL begin at the first edge with rst_n=1.

Structure
REQ-025 Shared package arb_pkg SHALL hold NUM_REQ=4, the IDX_W=2 constant, and the state enum {IDLE, BUSY}.
REQ-026 The rotating-priority search (inputs req and last; outputs one-hot winner, index and any) SHALL be a combinational sub-module named rr_pick4.
REQ-027 All outputs SHALL be driven directly from flops.

Verification
REQ-028 Reset, then req=4'b1111 held, done pulsed once per grant -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-029 req=4'b0100 from IDLE at edge k -> gnt=4'b0100, gnt_idx=2, gnt_valid=1 after edge k.
REQ-030 req=4'b0001 held with done=0 and MAX_HOLD=16 -> grant held 16 cycles, then gnt=0 with timeout=1 for one cycle, then requester 0 is re-granted.
REQ-031 done=1 in the same cycle as the tenure limit -> gnt drops with timeout=0.
REQ-032 While holding grant 1, req goes 4'b0010 -> 4'b1010 -> 4'b1000 -> gnt drops with no timeout; the next grant is to requester 3.
REQ-033 rst_n=0 during BUSY on requester 2 -> all outputs zero at that edge; after release, req=4'b0101 -> requester 0 is granted first.
